hazard_scoreboard: RTL

//  Hazard unit for the 5-stage core. Consumes the instruction-class flags and

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard unit bundle: D-stage decode flags/fields in, stall and forwarding
// selects plus the stall-cycle counter out.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_a3;
    logic             d_r_cal;
    logic             d_i_cal;
    logic             d_load;
    logic             d_store;
    logic             d_branch;
    logic             d_cbcl;
    logic             d_j_reg;
    logic             d_link;
    logic             d_sll;
    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_rs_e;
    logic [1:0]       fwd_rt_e;
    logic             fwd_rt_m;
    logic [CNT_W-1:0] stall_cnt;

    // Decoder side: drives the D-stage fields, observes the hazard decisions.
    modport master (
        output d_rs, d_rt, d_a3, d_r_cal, d_i_cal, d_load, d_store,
               d_branch, d_cbcl, d_j_reg, d_link, d_sll,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
               stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  d_rs, d_rt, d_a3, d_r_cal, d_i_cal, d_load, d_store,
               d_branch, d_cbcl, d_j_reg, d_link, d_sll,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
               stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage core. Tracks in-flight destinations in a
// shadow E/M/W pipeline with Tnew countdowns, stalls D using Tuse/Tnew, picks
// the nearest ready forwarding source for D, E and M, and counts stall cycles.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_scoreboard_if.slave    hz
);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Shadow pipeline state
    logic [4:0]       e_rs_q,   e_rs_d;
    logic [4:0]       e_rt_q,   e_rt_d;
    logic [4:0]       e_a3_q,   e_a3_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       m_rt_q,   m_rt_d;
    logic [4:0]       m_a3_q,   m_a3_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_a3_q,   w_a3_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Combinational decisions
    logic [1:0] tuse_rs_s;
    logic [1:0] tuse_rt_s;
    logic [4:0] new_a3_s;
    logic [1:0] new_tnew_s;
    logic       stall_rs_s;
    logic       stall_rt_s;
    logic       stall_s;

    // A stage holds the operand only if it writes a real (non-$0) register.
    function automatic logic reg_match(input logic [4:0] a3, input logic [4:0] r);
        return (a3 != 5'd0) && (a3 == r);
    endfunction

    // D-stage source: E (3) > M (2) > W (1) > GRF (0); a stage whose result
    // is not ready yet is skipped so an older ready copy can still be used.
    function automatic logic [1:0] fwd_sel_d(
        input logic [4:0] r,
        input logic [4:0] ea3, input logic [1:0] etnew,
        input logic [4:0] ma3, input logic [1:0] mtnew,
        input logic [4:0] wa3
    );
        logic [1:0] sel;
        if (reg_match(ea3, r) && (etnew == 2'd0)) begin
            sel = 2'd3;
        end else if (reg_match(ma3, r) && (mtnew == 2'd0)) begin
            sel = 2'd2;
        end else if (reg_match(wa3, r)) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // E-stage source: M (2) > W (1) > pipe register (0).
    function automatic logic [1:0] fwd_sel_e(
        input logic [4:0] r,
        input logic [4:0] ma3, input logic [1:0] mtnew,
        input logic [4:0] wa3
    );
        logic [1:0] sel;
        if (reg_match(ma3, r) && (mtnew == 2'd0)) begin
            sel = 2'd2;
        end else if (reg_match(wa3, r)) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Operand Tuse from the D-stage instruction class (3 = operand unused).
    always_comb begin
        tuse_rs_s = TUSE_NONE;
        tuse_rt_s = TUSE_NONE;
        if (hz.d_branch || hz.d_cbcl || hz.d_j_reg) begin
            tuse_rs_s = 2'd0;
            tuse_rt_s = 2'd0;
        end else if (hz.d_r_cal) begin
            tuse_rs_s = hz.d_sll ? TUSE_NONE : 2'd1;
            tuse_rt_s = 2'd1;
        end else if (hz.d_i_cal || hz.d_load || hz.d_store) begin
            tuse_rs_s = 2'd1;
            tuse_rt_s = hz.d_store ? 2'd2 : TUSE_NONE;
        end else begin
            tuse_rs_s = TUSE_NONE;
            tuse_rt_s = TUSE_NONE;
        end
    end

    // Tnew of the D instruction on entry to E; non-writers enter with a3=0.
    always_comb begin
        new_a3_s   = hz.d_a3;
        new_tnew_s = 2'd0;
        if (hz.d_load) begin
            new_tnew_s = 2'd2;
        end else if (hz.d_r_cal || hz.d_i_cal) begin
            new_tnew_s = 2'd1;
        end else if (hz.d_link || hz.d_cbcl) begin
            new_tnew_s = 2'd0;
        end else begin
            new_a3_s   = 5'd0;
            new_tnew_s = 2'd0;
        end
    end

    // Stall when an operand is needed before its in-flight producer is ready.
    always_comb begin
        stall_rs_s = 1'b0;
        stall_rt_s = 1'b0;
        if (tuse_rs_s != TUSE_NONE) begin
            stall_rs_s = (reg_match(e_a3_q, hz.d_rs) && (tuse_rs_s < e_tnew_q)) ||
                         (reg_match(m_a3_q, hz.d_rs) && (tuse_rs_s < m_tnew_q));
        end else begin
            stall_rs_s = 1'b0;
        end
        if (tuse_rt_s != TUSE_NONE) begin
            stall_rt_s = (reg_match(e_a3_q, hz.d_rt) && (tuse_rt_s < e_tnew_q)) ||
                         (reg_match(m_a3_q, hz.d_rt) && (tuse_rt_s < m_tnew_q));
        end else begin
            stall_rt_s = 1'b0;
        end
        stall_s = stall_rs_s || stall_rt_s;
    end

    // Shadow pipeline advance and saturating stall counter next state.
    always_comb begin
        w_a3_d   = m_a3_q;
        m_rt_d   = e_rt_q;
        m_a3_d   = e_a3_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : (e_tnew_q - 2'd1);
        e_rs_d   = 5'd0;
        e_rt_d   = 5'd0;
        e_a3_d   = 5'd0;
        e_tnew_d = 2'd0;
        if (stall_s) begin
            e_rs_d   = 5'd0;
            e_rt_d   = 5'd0;
            e_a3_d   = 5'd0;
            e_tnew_d = 2'd0;
        end else begin
            e_rs_d   = hz.d_rs;
            e_rt_d   = hz.d_rt;
            e_a3_d   = new_a3_s;
            e_tnew_d = new_tnew_s;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers; reset drops every in-flight entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q      <= 5'd0;
            e_rt_q      <= 5'd0;
            e_a3_q      <= 5'd0;
            e_tnew_q    <= 2'd0;
            m_rt_q      <= 5'd0;
            m_a3_q      <= 5'd0;
            m_tnew_q    <= 2'd0;
            w_a3_q      <= 5'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            e_rs_q      <= e_rs_d;
            e_rt_q      <= e_rt_d;
            e_a3_q      <= e_a3_d;
            e_tnew_q    <= e_tnew_d;
            m_rt_q      <= m_rt_d;
            m_a3_q      <= m_a3_d;
            m_tnew_q    <= m_tnew_d;
            w_a3_q      <= w_a3_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall     = stall_s;
    assign hz.fwd_rs_d  = fwd_sel_d(hz.d_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    assign hz.fwd_rt_d  = fwd_sel_d(hz.d_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    assign hz.fwd_rs_e  = fwd_sel_e(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
    assign hz.fwd_rt_e  = fwd_sel_e(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
    assign hz.fwd_rt_m  = reg_match(w_a3_q, m_rt_q);
    assign hz.stall_cnt = stall_cnt_q;

endmodule
